// File: rtl/rk_pkg.sv
// Shared definitions for the RK integrator datapath: default widths, op encoding
// and signed range helpers (valid for widths up to 64 bits).
package rk_pkg;

    localparam int DEF_N   = 32;
    localparam int DEF_SEG = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic logic [63:0] signed_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signed_min(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// SEG-bit ripple adder segment; also exposes the carry into its MSB so the
// final segment can derive signed overflow.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_into_msb
);

    logic [SEG-1:0] low;

    // Low SEG-1 bits in one add; the top bit of 'low' is the carry into the MSB.
    assign low        = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + {{(SEG-1){1'b0}}, cin};
    assign c_into_msb = low[SEG-1];
    assign sum        = {a[SEG-1] ^ b[SEG-1] ^ low[SEG-1], low[SEG-2:0]};
    assign cout       = (a[SEG-1] & b[SEG-1]) | (a[SEG-1] & low[SEG-1]) | (b[SEG-1] & low[SEG-1]);

endmodule

// File: rtl/addsub_pipe_nb.sv
// Pipelined signed add/subtract with one carry segment per stage, optional
// saturation, overflow flags and a valid/ready stream interface.
module addsub_pipe_nb
    import rk_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int SEG = DEF_SEG,
    parameter bit SAT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                op_sub,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] result,
    output logic                co,
    output logic                sign_flag,
    output logic                ovf
);

    localparam int L = N / SEG;
    localparam logic signed [N-1:0] S_MAX = N'(signed_max(N));
    localparam logic signed [N-1:0] S_MIN = N'(signed_min(N));

    // x_p[k]: segments below k hold resolved sum bits, segments k and up still hold operand A.
    logic           vld_p  [L];
    logic [N-1:0]   x_p    [L];
    logic [N-1:0]   b_p    [L];
    logic           c_p    [L];
    logic [N-1:0]   x_next [L];
    logic [SEG-1:0] seg_sum[L];
    logic           seg_co [L];
    logic           seg_cm [L];

    logic                adv;
    logic signed [N-1:0] raw;
    logic                ovf_c;
    logic                sign_c;

    function automatic logic signed [N-1:0] saturate(input logic signed [N-1:0] val,
                                                     input logic of, input logic neg);
        if (SAT && of)
            return neg ? S_MIN : S_MAX;
        return val;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < L; k++) begin : g_seg
        addsub_seg #(.SEG(SEG)) u_seg (
            .a          (x_p[k][k*SEG +: SEG]),
            .b          (b_p[k][k*SEG +: SEG]),
            .cin        (c_p[k]),
            .sum        (seg_sum[k]),
            .cout       (seg_co[k]),
            .c_into_msb (seg_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < L; k++) begin
            x_next[k] = x_p[k];
            x_next[k][k*SEG +: SEG] = seg_sum[k];
        end
    end

    assign raw    = x_next[L-1];
    assign ovf_c  = seg_cm[L-1] ^ seg_co[L-1];
    assign sign_c = raw[N-1] ^ ovf_c;

    // Stage 0 capture: subtraction becomes A + ~B with carry-in 1.
    always_ff @(posedge clk) begin
        if (adv) begin
            x_p[0] <= a;
            b_p[0] <= (op_sub == OP_SUB) ? ~b : b;
            c_p[0] <= (op_sub == OP_SUB);
            for (int k = 0; k < L - 1; k++) begin
                x_p[k+1] <= x_next[k];
                b_p[k+1] <= b_p[k];
                c_p[k+1] <= seg_co[k];
            end
        end
    end

    // Valid chain and output register; the final segment, flags and saturation land here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++)
                vld_p[k] <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            co        <= 1'b0;
            sign_flag <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 0; k < L - 1; k++)
                vld_p[k+1] <= vld_p[k];
            out_valid <= vld_p[L-1];
            if (vld_p[L-1]) begin
                result    <= saturate(raw, ovf_c, sign_c);
                co        <= seg_co[L-1];
                sign_flag <= sign_c;
                ovf       <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe_nb.sv
// Directed bench for addsub_pipe_nb: a wrap and a saturating instance share one
// input stream and are checked against hand-computed vectors.
module tb_addsub_pipe_nb;

    localparam int N  = 32;
    localparam int L  = 4;
    localparam int NV = 15;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        co;
        logic        sg;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic op_sub = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic out_ready = 1'b0;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic [N-1:0] result0, result1;
    logic co0, co1, sign0, sign1, ovf0, ovf1;

    int errors = 0;
    int checks = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    addsub_pipe_nb #(.N(N), .SEG(8), .SAT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .co(co0), .sign_flag(sign0), .ovf(ovf0)
    );

    addsub_pipe_nb #(.N(N), .SEG(8), .SAT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .co(co1), .sign_flag(sign1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input int i);
        chk($sformatf("v%0d_valid", i), {out_valid0, out_valid1}, 2'b11);
        chk($sformatf("v%0d_res_wrap", i), result0, vecs[i].r0);
        chk($sformatf("v%0d_res_sat", i), result1, vecs[i].r1);
        chk($sformatf("v%0d_co", i), {co0, co1}, {2{vecs[i].co}});
        chk($sformatf("v%0d_sign", i), {sign0, sign1}, {2{vecs[i].sg}});
        chk($sformatf("v%0d_ovf", i), {ovf0, ovf1}, {2{vecs[i].ov}});
    endtask

    task automatic drive_vec(input int i);
        in_valid = 1'b1;
        op_sub   = vecs[i].op;
        a        = vecs[i].a;
        b        = vecs[i].b;
    endtask

    // Single beat with out_ready=1: accepted at edge t, out_valid must rise at edge t+L.
    task automatic single_beat(input int i);
        @(negedge clk);
        out_ready = 1'b1;
        drive_vec(i);
        #1 chk("accept_ready", in_ready0, 1'b1);
        @(posedge clk);
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("lat_v%0d_c%0d", i, c), out_valid0, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        check_out(i);
    endtask

    initial begin
        vecs = '{
            '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0},
            '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
            '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b1},
            '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h00000005, 32'h80000000, 32'h80000005, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
            '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 32'h23456789, 1'b0, 1'b0, 1'b0},
            '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0},
            '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b1},
            '{1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 32'h000000FF, 1'b1, 1'b0, 1'b0},
            '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 32'h01000100, 1'b0, 1'b0, 1'b0},
            '{1'b1, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
            '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
            '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{1'b1, 32'h000000FF, 32'h00000100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0}
        };

        // Reset held while inputs toggle: outputs must stay cleared.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid  = c[0];
            op_sub    = c[1];
            a         = $urandom;
            b         = $urandom;
            out_ready = c[0];
            #1;
            chk("rst_valid", {out_valid0, out_valid1}, 2'b00);
            chk("rst_result", {result0, result1}, 64'd0);
            chk("rst_flags", {co0, sign0, ovf0, co1, sign1, ovf1}, 6'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {in_ready0, in_ready1}, 2'b11);

        // Directed single beats with latency check (sub 5-7, MAX+1, MIN-1, 0-0).
        for (int i = 0; i < 4; i++)
            single_beat(i);

        // Full stream with randomised backpressure, in-order and stability checks.
        begin
            int i_in = 0;
            int i_out = 0;
            int cyc = 0;
            logic hold = 1'b0;
            logic [N-1:0] held_res = '0;
            logic acc;
            while (i_out < NV && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (hold) begin
                    chk("hold_valid", out_valid0, 1'b1);
                    chk("hold_result", result0, held_res);
                end
                out_ready = 1'($urandom_range(0, 1));
                if (i_in < NV) drive_vec(i_in);
                else in_valid = 1'b0;
                #1;
                acc = in_valid && in_ready0;
                if (out_valid0 && out_ready) begin
                    check_out(i_out);
                    i_out++;
                end
                hold     = out_valid0 && !out_ready;
                held_res = result0;
                @(posedge clk);
                if (acc) i_in++;
            end
            chk("stream_count", i_out, NV);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < L + 2; c++) begin
                @(negedge clk);
                chk("no_extra_beat", out_valid0, 1'b0);
            end
        end

        // Reset with three beats in flight: none may emerge afterwards.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 4; i < 7; i++) begin
            drive_vec(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("midrst_valid", {out_valid0, out_valid1}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < L + 2; c++) begin
            @(negedge clk);
            chk("midrst_drained", {out_valid0, out_valid1}, 2'b00);
        end
        single_beat(7);
        single_beat(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
